// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with stall/flush handling, halt drain sequencing,
// a captured-instruction counter and a sticky error flag.
module ex_mem_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] aluOut,
    input  logic [DATA_W-1:0] setVal,
    input  logic [DATA_W-1:0] reg1Data,
    input  logic [DATA_W-1:0] reg2Data,
    input  logic [DATA_W-1:0] nextPc,
    input  logic [DATA_W-1:0] instr,
    input  logic              memEn,
    input  logic              memWrt,
    input  logic              regWrt,
    input  logic              halt,
    input  logic              err,
    input  logic [2:0]        regWrtSrc,
    input  logic [2:0]        writeReg,
    output logic [DATA_W-1:0] aluOutOut,
    output logic [DATA_W-1:0] setValOut,
    output logic [DATA_W-1:0] reg1DataOut,
    output logic [DATA_W-1:0] reg2DataOut,
    output logic [DATA_W-1:0] nextPcOut,
    output logic [DATA_W-1:0] instrOut,
    output logic              memEnOut,
    output logic              memWrtOut,
    output logic              regWrtOut,
    output logic              haltOut,
    output logic [2:0]        regWrtSrcOut,
    output logic [2:0]        writeRegOut,
    output logic              validOut,
    output logic              errOut,
    output logic              haltedOut,
    output logic [15:0]       instrCnt
);

    localparam logic [DATA_W-1:0] NOP_INSTR = DATA_W'(16'h0800);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t state;
    state_t stateNext;
    logic   capture;
    logic   loadBubble;

    // Writing back from source select 7 is an illegal encoding.
    function automatic logic errCheck(input logic e, input logic rw, input logic [2:0] src);
        return e || (rw && (src == 3'h7));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            RUN:     if (capture && halt) stateNext = DRAIN;
            DRAIN:   if (!stall) stateNext = HALTED;
            HALTED:  stateNext = HALTED;
            default: stateNext = RUN;
        endcase
    end

    // Flush outranks stall in RUN; DRAIN only waits out stall, never flush.
    always_comb begin
        capture    = 1'b0;
        loadBubble = 1'b0;
        case (state)
            RUN: begin
                if (flush)       loadBubble = 1'b1;
                else if (!stall) begin
                    if (valid) capture    = 1'b1;
                    else       loadBubble = 1'b1;
                end
            end
            DRAIN:   loadBubble = !stall;
            default: loadBubble = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || loadBubble) begin
            aluOutOut    <= '0;
            setValOut    <= '0;
            reg1DataOut  <= '0;
            reg2DataOut  <= '0;
            nextPcOut    <= '0;
            instrOut     <= NOP_INSTR;
            memEnOut     <= 1'b0;
            memWrtOut    <= 1'b0;
            regWrtOut    <= 1'b0;
            haltOut      <= 1'b0;
            regWrtSrcOut <= 3'h0;
            writeRegOut  <= 3'h0;
            validOut     <= 1'b0;
        end else if (capture) begin
            aluOutOut    <= aluOut;
            setValOut    <= setVal;
            reg1DataOut  <= reg1Data;
            reg2DataOut  <= reg2Data;
            nextPcOut    <= nextPc;
            instrOut     <= instr;
            memEnOut     <= memEn;
            memWrtOut    <= memWrt;
            regWrtOut    <= regWrt;
            haltOut      <= halt;
            regWrtSrcOut <= regWrtSrc;
            writeRegOut  <= writeReg;
            validOut     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instrCnt <= 16'h0000;
            errOut   <= 1'b0;
        end else if (capture) begin
            instrCnt <= instrCnt + 16'h0001;
            if (errCheck(err, regWrt, regWrtSrc)) errOut <= 1'b1;
        end
    end

    assign haltedOut = (state == HALTED);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized and directed bench for ex_mem_reg against a cycle-level
// behavioural model of the register's visible contents.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst, valid, stall, flush;
    logic [15:0] aluOut, setVal, reg1Data, reg2Data, nextPc, instr;
    logic        memEn, memWrt, regWrt, halt, err;
    logic [2:0]  regWrtSrc, writeReg;
    logic [15:0] aluOutOut, setValOut, reg1DataOut, reg2DataOut, nextPcOut, instrOut;
    logic        memEnOut, memWrtOut, regWrtOut, haltOut;
    logic [2:0]  regWrtSrcOut, writeRegOut;
    logic        validOut, errOut, haltedOut;
    logic [15:0] instrCnt;

    ex_mem_reg dut (
        .clk(clk), .rst(rst), .valid(valid), .stall(stall), .flush(flush),
        .aluOut(aluOut), .setVal(setVal), .reg1Data(reg1Data), .reg2Data(reg2Data),
        .nextPc(nextPc), .instr(instr), .memEn(memEn), .memWrt(memWrt),
        .regWrt(regWrt), .halt(halt), .err(err), .regWrtSrc(regWrtSrc),
        .writeReg(writeReg), .aluOutOut(aluOutOut), .setValOut(setValOut),
        .reg1DataOut(reg1DataOut), .reg2DataOut(reg2DataOut), .nextPcOut(nextPcOut),
        .instrOut(instrOut), .memEnOut(memEnOut), .memWrtOut(memWrtOut),
        .regWrtOut(regWrtOut), .haltOut(haltOut), .regWrtSrcOut(regWrtSrcOut),
        .writeRegOut(writeRegOut), .validOut(validOut), .errOut(errOut),
        .haltedOut(haltedOut), .instrCnt(instrCnt)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    // Model: contents as a list of fields plus a mode description.
    logic [15:0] eData[6];
    logic        eMemEn, eMemWrt, eRegWrt, eHalt, eValid, eErr;
    logic [2:0]  eSrc, eWreg;
    logic [15:0] eCnt;
    bit          draining, halted;

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelBubble();
        for (int i = 0; i < 6; i++) eData[i] = 16'h0000;
        eData[5] = 16'h0800;
        {eMemEn, eMemWrt, eRegWrt, eHalt, eValid} = '0;
        eSrc = 3'h0;
        eWreg = 3'h0;
    endtask

    task automatic modelEdge();
        if (rst) begin
            modelBubble();
            draining = 0; halted = 0; eCnt = 0; eErr = 0;
        end else if (halted) begin
            modelBubble();
        end else if (draining) begin
            if (!stall) begin
                modelBubble();
                draining = 0;
                halted = 1;
            end
        end else if (flush) begin
            modelBubble();
        end else if (!stall) begin
            if (valid) begin
                eData[0] = aluOut; eData[1] = setVal; eData[2] = reg1Data;
                eData[3] = reg2Data; eData[4] = nextPc; eData[5] = instr;
                eMemEn = memEn; eMemWrt = memWrt; eRegWrt = regWrt; eHalt = halt;
                eSrc = regWrtSrc; eWreg = writeReg; eValid = 1;
                eCnt = eCnt + 1;
                if (err || (regWrt && regWrtSrc == 3'd7)) eErr = 1;
                if (halt) draining = 1;
            end else begin
                modelBubble();
            end
        end
    endtask

    task automatic compareAll();
        checkVal("data",
                 {aluOutOut, setValOut, reg1DataOut, reg2DataOut, nextPcOut, instrOut},
                 {eData[0], eData[1], eData[2], eData[3], eData[4], eData[5]});
        checkVal("ctrl",
                 {memEnOut, memWrtOut, regWrtOut, haltOut, validOut, errOut, haltedOut,
                  regWrtSrcOut, writeRegOut},
                 {eMemEn, eMemWrt, eRegWrt, eHalt, eValid, eErr, halted, eSrc, eWreg});
        checkVal("cnt", instrCnt, eCnt);
    endtask

    task automatic step(input bit chk);
        @(posedge clk);
        modelEdge();
        #1;
        if (chk) compareAll();
    endtask

    task automatic clearInputs();
        {rst, valid, stall, flush, memEn, memWrt, regWrt, halt, err} = '0;
        {aluOut, setVal, reg1Data, reg2Data, nextPc, instr} = '0;
        regWrtSrc = 3'h0;
        writeReg = 3'h0;
    endtask

    task automatic randInputs();
        valid = ($urandom_range(3) != 0);
        stall = ($urandom_range(3) == 0);
        flush = ($urandom_range(9) == 0);
        aluOut = 16'($urandom); setVal = 16'($urandom); reg1Data = 16'($urandom);
        reg2Data = 16'($urandom); nextPc = 16'($urandom); instr = 16'($urandom);
        memEn = 1'($urandom); memWrt = 1'($urandom); regWrt = 1'($urandom);
        halt = ($urandom_range(29) == 0);
        err = ($urandom_range(19) == 0);
        regWrtSrc = 3'($urandom); writeReg = 3'($urandom);
        rst = ($urandom_range(59) == 0);
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1;
        step(1);
        rst = 0;
    endtask

    logic [15:0] cntSnap;

    initial begin
        clearInputs();
        rst = 1;
        modelBubble();
        eCnt = 0; eErr = 0; draining = 0; halted = 0;
        step(1);
        checkVal("rst_instr", instrOut, 16'h0800);
        checkVal("rst_valid", validOut, 1'b0);
        checkVal("rst_cnt", instrCnt, 16'h0000);
        rst = 0;

        // Pass-through
        valid = 1; aluOut = 16'h1234; writeReg = 3'h5; regWrt = 1;
        step(1);
        checkVal("pass_alu", aluOutOut, 16'h1234);
        checkVal("pass_wreg", writeRegOut, 3'h5);
        checkVal("pass_rw", regWrtOut, 1'b1);
        checkVal("pass_valid", validOut, 1'b1);
        checkVal("pass_cnt", instrCnt, 16'h0001);

        // Stall hold
        clearInputs();
        valid = 1; instr = 16'hA5A5;
        step(1);
        cntSnap = instrCnt;
        for (int i = 0; i < 3; i++) begin
            randInputs();
            rst = 0; flush = 0; stall = 1;
            step(1);
            checkVal("stall_instr", instrOut, 16'hA5A5);
            checkVal("stall_cnt", instrCnt, cntSnap);
        end

        // Flush beats stall; flushed error does not stick
        clearInputs();
        stall = 1; flush = 1; valid = 1; memWrt = 1; err = 1;
        step(1);
        checkVal("flush_instr", instrOut, 16'h0800);
        checkVal("flush_memwrt", memWrtOut, 1'b0);
        checkVal("flush_valid", validOut, 1'b0);
        checkVal("flush_err", errOut, 1'b0);

        // Halt drain
        clearInputs();
        valid = 1; halt = 1; instr = 16'h1357;
        step(1);
        checkVal("halt_haltout", haltOut, 1'b1);
        checkVal("halt_notyet", haltedOut, 1'b0);
        clearInputs();
        flush = 1; stall = 1;
        step(1);
        checkVal("drain_stall_instr", instrOut, 16'h1357);
        stall = 0;
        step(1);
        checkVal("drain_halted", haltedOut, 1'b1);
        checkVal("drain_bubble", instrOut, 16'h0800);
        cntSnap = instrCnt;
        for (int i = 0; i < 4; i++) begin
            randInputs();
            rst = 0; valid = 1;
            step(1);
            checkVal("halted_cnt", instrCnt, cntSnap);
            checkVal("halted_flag", haltedOut, 1'b1);
        end

        // Sticky error
        doReset();
        valid = 1; regWrt = 1; regWrtSrc = 3'h7;
        step(1);
        checkVal("err_set", errOut, 1'b1);
        clearInputs();
        for (int i = 0; i < 10; i++) begin
            valid = 1; aluOut = 16'(i);
            step(1);
        end
        checkVal("err_sticky", errOut, 1'b1);
        doReset();
        checkVal("err_clear", errOut, 1'b0);

        // Counter wrap
        clearInputs();
        valid = 1;
        for (int i = 0; i < 65535; i++) step(0);
        checkVal("cnt_ffff", instrCnt, 16'hFFFF);
        step(1);
        checkVal("cnt_wrap", instrCnt, 16'h0000);

        // Reset from DRAIN
        halt = 1;
        step(1);
        clearInputs();
        rst = 1; stall = 1;
        step(1);
        checkVal("rst_drain_valid", validOut, 1'b0);
        checkVal("rst_drain_instr", instrOut, 16'h0800);
        rst = 0; stall = 0; valid = 1; instr = 16'h4242;
        step(1);
        checkVal("rst_drain_run", {validOut, instrOut}, {1'b1, 16'h4242});

        // Randomized
        for (int i = 0; i < 2000; i++) begin
            randInputs();
            step(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk and rst, with clk first and rst second.
REQ-002 The port list SHALL be as follows (width and meaning per port):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- valid  in  1  execute-stage output holds a real instruction.
- stall  in  1  hold current contents (memory-side busy or hazard).
- flush  in  1  replace the incoming instruction with a bubble.
- aluOut, setVal, reg1Data, reg2Data, nextPc, instr  in  16 each  execute-stage results and instruction word.
- memEn, memWrt, regWrt, halt, err  in  1 each  execute-stage control and error flags.
- regWrtSrc, writeReg  in  3 each  write-back source select and destination register.
- aluOutOut, setValOut, reg1DataOut, reg2DataOut, nextPcOut, instrOut  out  16 each  registered copies for the memory stage.
- memEnOut, memWrtOut, regWrtOut, haltOut  out  1 each  registered control flags.
- regWrtSrcOut, writeRegOut  out  3 each  registered selects.
- validOut  out  1  register holds a real instruction.
- errOut  out  1  sticky error flag.
- haltedOut  out  1  pipeline drained after halt.
- instrCnt  out  16  count of valid instructions captured.

Function
REQ-003 Bubble SHALL be defined as: all 1-bit outputs 0, all 16-bit data outputs 16'h0000 except instrOut=16'h0800 (NOP), regWrtSrcOut=3'h0, writeRegOut=3'h0, validOut=0.
REQ-004 State machine SHALL have states RUN, DRAIN and HALTED; reset state is RUN.
REQ-005 In RUN with stall=0 and flush=0 and valid=1, all outputs SHALL load their inputs on the next rising edge (1-cycle latency) and validOut SHALL become 1.
REQ-006 In RUN with stall=0 and flush=0 and valid=0, the register SHALL load a bubble.
REQ-007 In RUN, flush=1 SHALL load a bubble regardless of stall and valid (flush priority over stall).
REQ-008 In RUN, stall=1 with flush=0 SHALL hold all outputs unchanged; instrCnt SHALL NOT increment.
REQ-009 A capture under REQ-005 with halt=1 SHALL move the state to DRAIN, with haltOut=1 registered alongside the instruction.
REQ-010 In DRAIN, the next edge with stall=0 SHALL load a bubble and move the state to HALTED; stall=1 SHALL hold both the state and the contents.
REQ-011 In HALTED, the register SHALL hold a bubble, ignore valid, stall and flush, keep haltedOut=1, and stay in HALTED until rst.
REQ-012 In DRAIN, flush SHALL be ignored; the captured halt is never cancelled.
REQ-013 instrCnt SHALL increment by 1 on every REQ-005 capture and wrap from 16'hFFFF to 16'h0000.
REQ-014 errOut SHALL set on any REQ-005 capture where err=1, or where regWrt=1 and regWrtSrc=3'h7.
REQ-015 Once set, errOut SHALL hold until rst; a flushed or stalled input SHALL NOT set errOut.
REQ-016 The block SHALL NOT alter data values: there is no sign extension or width change, and every field is passed through bit-exact.

Reset
REQ-017 rst=1 at a rising edge SHALL load a bubble, set the state to RUN, and clear instrCnt, errOut and haltedOut.
REQ-018 Reset SHALL take priority over stall, flush and any state, including DRAIN and HALTED.
REQ-019 All outputs SHALL be valid from the first edge with rst=1; there is no asynchronous path.

Verification
REQ-020 Pass-through: valid=1, aluOut=16'h1234, writeReg=3'h5, regWrt=1, no stall -> next cycle aluOutOut=16'h1234, writeRegOut=5, regWrtOut=1, validOut=1, instrCnt=1.
REQ-021 Stall hold: capture instr=16'hA5A5, then stall=1 for 3 cycles with changing inputs -> instrOut stays 16'hA5A5 and instrCnt is unchanged.
REQ-022 Flush vs stall: stall=1, flush=1, valid=1, memWrt=1 -> next cycle instrOut=16'h0800, memWrtOut=0, validOut=0.
REQ-023 Halt drain: capture halt=1 -> haltOut=1 next cycle; following cycle bubble with haltedOut=1; later valid inputs are ignored and instrCnt is frozen.
REQ-024 Error sticky: valid=1, regWrt=1, regWrtSrc=3'h7 -> errOut=1, which stays 1 through 10 clean cycles; rst clears it.
REQ-025 Counter wrap and reset: preload via 65535 captures, then one more -> instrCnt=16'h0000; rst asserted in DRAIN -> state RUN and bubble on the next edge.
